// File: rtl/pad_share_arbiter_if.sv
// Pad-share bus: requester-side request/grant/data lanes plus the pad-cell side.
// The arbiter connects through the slave modport, the environment through master.
interface pad_share_arbiter_if #(
  parameter int NREQ    = 3,
  parameter int PADATTR = 16
);

  // Requester side
  logic [NREQ-1:0]         req_i;
  logic [NREQ-1:0]         gnt_o;
  logic [NREQ-1:0]         drv_i;
  logic [NREQ-1:0]         oe_i;
  logic [NREQ*PADATTR-1:0] attr_i;
  logic [NREQ-1:0]         rd_o;

  // Pad cell side
  logic                    pad_in_o;
  logic                    pad_oe_o;
  logic [PADATTR-1:0]      pad_attributes_o;
  logic                    pad_out_i;

  modport slave (
    input  req_i, drv_i, oe_i, attr_i, pad_out_i,
    output gnt_o, rd_o, pad_in_o, pad_oe_o, pad_attributes_o
  );

  modport master (
    output req_i, drv_i, oe_i, attr_i, pad_out_i,
    input  gnt_o, rd_o, pad_in_o, pad_oe_o, pad_attributes_o
  );

endinterface

// File: rtl/pad_share_arbiter.sv
// Time-shares one bidirectional pad cell between NREQ requesters.
// Round-robin ownership, optional preemption of a contended owner after
// MAX_HOLD cycles, and a forced output-enable-low gap of TURN_CYCLES on every
// change of owner so that two drivers can never overlap on the pad.
module pad_share_arbiter #(
  parameter int                 NREQ         = 3,
  parameter int                 PADATTR      = 16,
  parameter int                 TURN_CYCLES  = 2,
  parameter int                 MAX_HOLD     = 8,
  parameter logic [PADATTR-1:0] DEFAULT_ATTR = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  pad_share_arbiter_if.slave bus
);

  // Parameter legality is checked at elaboration time.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("pad_share_arbiter: NREQ must be in 2..8");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("pad_share_arbiter: TURN_CYCLES must be >= 1");
  end
  if (MAX_HOLD < 0) begin : g_bad_hold
    $error("pad_share_arbiter: MAX_HOLD must be >= 0");
  end

  localparam int OWN_W  = $clog2(NREQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  typedef logic [OWN_W-1:0] own_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  own_t                own_q,   own_d;
  own_t                ptr_q,   ptr_d;
  logic [HOLD_W-1:0]   hold_q,  hold_d;
  logic [TURN_W-1:0]   turn_q,  turn_d;

  logic [NREQ-1:0]     gnt_vec;
  logic [PADATTR-1:0]  attr_arr [NREQ];
  logic                any_req;
  logic                others_pending;
  logic                preempt;
  logic                win_found;
  own_t                win_idx;
  logic [OWN_W:0]      rr_sum;

  // Unpack the flat attribute bus into one entry per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      attr_arr[i] = bus.attr_i[i*PADATTR +: PADATTR];
    end
  end

  // Grant vector is a decode of registered state only, so it carries no
  // combinational path from the request inputs.
  always_comb begin
    gnt_vec = '0;
    if (state_q == ST_GRANT) begin
      gnt_vec[own_q] = 1'b1;
    end
  end

  assign any_req        = |bus.req_i;
  assign others_pending = |(bus.req_i & ~gnt_vec);
  assign preempt        = (MAX_HOLD != 0) && others_pending && (hold_q == HOLD_LAST);

  // Round-robin search: start just after the last winner and wrap to 0.
  // NOTE: every variable written here is given a value before any branch,
  // otherwise the tool would infer latches to hold the old value.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (OWN_W+1)'(k);
      if (rr_sum >= (OWN_W+1)'(NREQ)) begin
        rr_sum = rr_sum - (OWN_W+1)'(NREQ);
      end
      if (!win_found && bus.req_i[rr_sum[OWN_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[OWN_W-1:0];
      end
    end
  end

  // Next-state logic: IDLE -> GRANT -> TURN -> GRANT/IDLE.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          own_d   = win_idx;
          ptr_d   = win_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        hold_d = others_pending ? hold_q + 1'b1 : '0;
        // A released or preempted owner always passes through TURN, never
        // straight to the next owner.
        if (!bus.req_i[own_q] || preempt) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          if (any_req) begin
            state_d = ST_GRANT;
            own_d   = win_idx;
            ptr_d   = win_idx;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset gives requester 0 first priority.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= own_t'(NREQ - 1);
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  // Pad cell drive: owner's signals in GRANT, safe idle values otherwise.
  always_comb begin
    bus.pad_oe_o         = 1'b0;
    bus.pad_in_o         = 1'b0;
    bus.pad_attributes_o = DEFAULT_ATTR;
    if (state_q == ST_GRANT) begin
      bus.pad_oe_o         = bus.oe_i[own_q];
      bus.pad_in_o         = bus.drv_i[own_q] & bus.oe_i[own_q];
      bus.pad_attributes_o = attr_arr[own_q];
    end
  end

  assign bus.gnt_o = gnt_vec;
  assign bus.rd_o  = {NREQ{bus.pad_out_i}} & gnt_vec;

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Directed testbench for pad_share_arbiter (NREQ=3, TURN_CYCLES=2, MAX_HOLD=8).
module tb_pad_share_arbiter;

  localparam int NREQ        = 3;
  localparam int PADATTR     = 16;
  localparam int TURN_CYCLES = 2;
  localparam int MAX_HOLD    = 8;
  localparam logic [PADATTR-1:0]      DEF_ATTR = 16'h5A5A;
  localparam logic [NREQ*PADATTR-1:0] ATTRS    = {16'hC002, 16'hB001, 16'hA000};

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pad_share_arbiter_if #(.NREQ(NREQ), .PADATTR(PADATTR)) bus ();

  pad_share_arbiter #(
    .NREQ        (NREQ),
    .PADATTR     (PADATTR),
    .TURN_CYCLES (TURN_CYCLES),
    .MAX_HOLD    (MAX_HOLD),
    .DEFAULT_ATTR(DEF_ATTR)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    bus.req_i     = '0;
    bus.drv_i     = '0;
    bus.oe_i      = '0;
    bus.attr_i    = ATTRS;
    bus.pad_out_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    bus.req_i     = 3'b111;
    bus.drv_i     = 3'b111;
    bus.oe_i      = 3'b111;
    bus.attr_i    = ATTRS;
    bus.pad_out_i = 1'b1;
    repeat (2) tick();
    vectors++;
    if (bus.gnt_o !== 3'b000) begin
      miscompares++; $display("FAIL reset_gnt got %b want 000", bus.gnt_o);
    end
    vectors++;
    if (bus.pad_oe_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_oe got %b want 0", bus.pad_oe_o);
    end
    vectors++;
    if (bus.pad_in_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_in got %b want 0", bus.pad_in_o);
    end
    vectors++;
    if (bus.pad_attributes_o !== DEF_ATTR) begin
      miscompares++; $display("FAIL reset_attr got %h want %h", bus.pad_attributes_o, DEF_ATTR);
    end
    vectors++;
    if (bus.rd_o !== 3'b000) begin
      miscompares++; $display("FAIL reset_rd got %b want 000", bus.rd_o);
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    bus.oe_i      = 3'b111;
    bus.drv_i     = 3'b001;
    bus.pad_out_i = 1'b1;
    bus.req_i     = 3'b001;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001) begin
      miscompares++; $display("FAIL single_gnt got %b want 001", bus.gnt_o);
    end
    vectors++;
    if (bus.pad_oe_o !== 1'b1) begin
      miscompares++; $display("FAIL single_oe got %b want 1", bus.pad_oe_o);
    end
    vectors++;
    if (bus.pad_in_o !== 1'b1) begin
      miscompares++; $display("FAIL single_in got %b want 1", bus.pad_in_o);
    end
    vectors++;
    if (bus.pad_attributes_o !== 16'hA000) begin
      miscompares++; $display("FAIL single_attr got %h want a000", bus.pad_attributes_o);
    end
    vectors++;
    if (bus.rd_o !== 3'b001) begin
      miscompares++; $display("FAIL single_rd1 got %b want 001", bus.rd_o);
    end
    bus.pad_out_i = 1'b0;
    #1;
    vectors++;
    if (bus.rd_o !== 3'b000) begin
      miscompares++; $display("FAIL single_rd0 got %b want 000", bus.rd_o);
    end
    bus.drv_i = 3'b110;
    #1;
    vectors++;
    if (bus.pad_in_o !== 1'b0 || bus.pad_oe_o !== 1'b1) begin
      miscompares++; $display("FAIL single_drv0 got in=%b oe=%b want in=0 oe=1", bus.pad_in_o, bus.pad_oe_o);
    end
    // Owner floats the pad but keeps ownership.
    bus.drv_i = 3'b001;
    bus.oe_i  = 3'b110;
    #1;
    vectors++;
    if (bus.pad_oe_o !== 1'b0 || bus.pad_in_o !== 1'b0 || bus.gnt_o !== 3'b001) begin
      miscompares++; $display("FAIL single_float got oe=%b in=%b gnt=%b want oe=0 in=0 gnt=001",
                              bus.pad_oe_o, bus.pad_in_o, bus.gnt_o);
    end
    bus.oe_i = 3'b111;
    // No contention: ownership lasts well beyond MAX_HOLD.
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b001) begin
        miscompares++; $display("FAIL single_hold c=%0d got %b want 001", c, bus.gnt_o);
      end
    end
    bus.req_i = 3'b000;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b000 || bus.pad_oe_o !== 1'b0 || bus.pad_attributes_o !== DEF_ATTR) begin
        miscompares++; $display("FAIL single_release c=%0d got gnt=%b oe=%b attr=%h want 000 0 %h",
                                c, bus.gnt_o, bus.pad_oe_o, bus.pad_attributes_o, DEF_ATTR);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]         exp_gnt;
    logic [PADATTR-1:0] exp_attr;
    int                 owner;
    do_reset();
    bus.oe_i  = 3'b111;
    bus.drv_i = 3'b111;
    bus.req_i = 3'b111;
    for (int seg = 0; seg < 4; seg++) begin
      owner    = seg % 3;
      exp_gnt  = 3'b001 << owner;
      exp_attr = (owner == 0) ? 16'hA000 : (owner == 1) ? 16'hB001 : 16'hC002;
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        vectors++;
        if (bus.gnt_o !== exp_gnt || bus.pad_oe_o !== 1'b1 || bus.pad_attributes_o !== exp_attr) begin
          miscompares++; $display("FAIL rr_grant seg=%0d c=%0d got gnt=%b oe=%b attr=%h want %b 1 %h",
                                  seg, c, bus.gnt_o, bus.pad_oe_o, bus.pad_attributes_o, exp_gnt, exp_attr);
        end
      end
      for (int t = 0; t < TURN_CYCLES; t++) begin
        tick();
        vectors++;
        if (bus.gnt_o !== 3'b000 || bus.pad_oe_o !== 1'b0 || bus.pad_attributes_o !== DEF_ATTR) begin
          miscompares++; $display("FAIL rr_turn seg=%0d t=%0d got gnt=%b oe=%b attr=%h want 000 0 %h",
                                  seg, t, bus.gnt_o, bus.pad_oe_o, bus.pad_attributes_o, DEF_ATTR);
        end
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    bus.oe_i  = 3'b111;
    bus.req_i = 3'b001;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001) begin
      miscompares++; $display("FAIL pre_first got %b want 001", bus.gnt_o);
    end
    bus.req_i = 3'b011;
    for (int c = 2; c <= 8; c++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b001) begin
        miscompares++; $display("FAIL pre_hold0 cyc=%0d got %b want 001", c, bus.gnt_o);
      end
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b000 || bus.pad_oe_o !== 1'b0) begin
        miscompares++; $display("FAIL pre_turn0 t=%0d got gnt=%b oe=%b want 000 0", t, bus.gnt_o, bus.pad_oe_o);
      end
    end
    // Owner 1 now holds for 8 contended cycles; preempted owner 0 re-competes.
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b010) begin
        miscompares++; $display("FAIL pre_hold1 c=%0d got %b want 010", c, bus.gnt_o);
      end
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b000) begin
        miscompares++; $display("FAIL pre_turn1 t=%0d got %b want 000", t, bus.gnt_o);
      end
    end
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001) begin
      miscompares++; $display("FAIL pre_back0 got %b want 001", bus.gnt_o);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    bus.oe_i  = 3'b111;
    bus.req_i = 3'b100;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b100 || bus.pad_attributes_o !== 16'hC002) begin
      miscompares++; $display("FAIL hand_own2 got gnt=%b attr=%h want 100 c002", bus.gnt_o, bus.pad_attributes_o);
    end
    bus.req_i = 3'b001;
    for (int t = 0; t < 2; t++) begin
      tick();
      vectors++;
      if (bus.gnt_o !== 3'b000 || bus.pad_oe_o !== 1'b0 || bus.pad_attributes_o !== DEF_ATTR) begin
        miscompares++; $display("FAIL hand_turn t=%0d got gnt=%b oe=%b attr=%h want 000 0 %h",
                                t, bus.gnt_o, bus.pad_oe_o, bus.pad_attributes_o, DEF_ATTR);
      end
    end
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001 || bus.pad_attributes_o !== 16'hA000) begin
      miscompares++; $display("FAIL hand_own0 got gnt=%b attr=%h want 001 a000", bus.gnt_o, bus.pad_attributes_o);
    end
  endtask

  task automatic test_pulse_and_drop();
    do_reset();
    bus.oe_i  = 3'b111;
    bus.req_i = 3'b010;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b010) begin
      miscompares++; $display("FAIL pulse_gnt got %b want 010", bus.gnt_o);
    end
    bus.req_i = 3'b000;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b000) begin
      miscompares++; $display("FAIL pulse_turn0 got %b want 000", bus.gnt_o);
    end
    // Requester 2 rises and drops before the arbitration cycle.
    bus.req_i = 3'b100;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b000) begin
      miscompares++; $display("FAIL pulse_turn1 got %b want 000", bus.gnt_o);
    end
    bus.req_i = 3'b000;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b000) begin
      miscompares++; $display("FAIL drop_before_grant got %b want 000", bus.gnt_o);
    end
    bus.req_i = 3'b001;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001) begin
      miscompares++; $display("FAIL idle_latency got %b want 001", bus.gnt_o);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.oe_i      = 3'b111;
    bus.drv_i     = 3'b111;
    bus.pad_out_i = 1'b1;
    bus.req_i     = 3'b001;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001 || bus.pad_oe_o !== 1'b1) begin
      miscompares++; $display("FAIL midrst_pre got gnt=%b oe=%b want 001 1", bus.gnt_o, bus.pad_oe_o);
    end
    // Move the owner pointer to 0, then reset between clock edges.
    #2;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (bus.pad_oe_o !== 1'b0 || bus.gnt_o !== 3'b000 || bus.rd_o !== 3'b000 || bus.pad_in_o !== 1'b0) begin
      miscompares++; $display("FAIL midrst_async got oe=%b gnt=%b rd=%b in=%b want 0 000 000 0",
                              bus.pad_oe_o, bus.gnt_o, bus.rd_o, bus.pad_in_o);
    end
    bus.req_i = 3'b111;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    vectors++;
    if (bus.gnt_o !== 3'b001) begin
      miscompares++; $display("FAIL midrst_first got %b want 001", bus.gnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_round_robin();
    test_preempt();
    test_handoff();
    test_pulse_and_drop();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
